boot_loader: RTL and testbench

- Upstream of the machine's instruction memory.
- Accepts a byte stream from a serial receiver and assembles it into 16-bit words. Writes those words sequentially into I_MEM through its write port.
- Holds the CPU in reset until the image is loaded and its checksum verifies.
- Top level muxes I_MEM st/addr/data to this block while cpu_hold=1.

---
 rtl/boot_loader.sv | 70 +++++++
 tb/tb_boot_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: assembles a framed serial byte stream into 16-bit I_MEM words and
// holds the CPU in reset until the image checksum verifies.
module boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);
  typedef enum logic [3:0] {WAIT_SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [15:0] count, index, cnt_n;
  logic [7:0] word_hi, csum;
  logic acc;
  assign rx_ready = state inside {WAIT_SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
  assign mem_we = state == WRITE;
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign err = state == ERROR;
  assign acc = rx_valid && rx_ready;
  assign cnt_n = {count[15:8], rx_data};
  always_ff @(posedge clk)
    if (reset) state <= WAIT_SYNC;
    else state <= state_n;
  // every accepting state has rx_ready=1, so rx_valid alone marks a handshake here
  always_comb begin
    state_n = state;
    case (state)
      WAIT_SYNC: state_n = rx_valid && rx_data == SYNC_BYTE ? CNT_HI : WAIT_SYNC;
      CNT_HI:    state_n = rx_valid ? CNT_LO : CNT_HI;
      CNT_LO:    state_n = !rx_valid ? CNT_LO : cnt_n > MAX_WORDS ? ERROR : cnt_n == 16'd0 ? CHECK : DATA_HI;
      DATA_HI:   state_n = rx_valid ? DATA_LO : DATA_HI;
      DATA_LO:   state_n = rx_valid ? WRITE : DATA_LO;
      WRITE:     state_n = index + 16'd1 == count ? CHECK : DATA_HI;
      CHECK:     state_n = !rx_valid ? CHECK : rx_data == csum ? DONE : ERROR;
      default:   state_n = state;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      count <= 16'd0;
      index <= 16'd0;
      word_hi <= 8'd0;
      csum <= 8'd0;
      mem_addr <= BASE_ADDR;
      mem_wdata <= 16'd0;
    end else begin
      if (acc && state == WAIT_SYNC && rx_data == SYNC_BYTE) csum <= 8'd0;
      else if (acc && state inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO}) csum <= csum ^ rx_data;
      if (acc && state == CNT_HI) count[15:8] <= rx_data;
      if (acc && state == CNT_LO) count[7:0] <= rx_data;
      if (acc && state == DATA_HI) word_hi <= rx_data;
      // address/data registered on the low byte so they are stable throughout WRITE
      if (acc && state == DATA_LO) begin
        mem_addr <= BASE_ADDR + index;
        mem_wdata <= {word_hi, rx_data};
      end
      if (state == WRITE) index <= index + 16'd1;
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames against boot_loader built with MAX_WORDS=4.
module tb_boot_loader;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, reset = 1, rx_valid = 0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, mem_we, cpu_hold, done, err;
  logic [15:0] mem_addr, mem_wdata;
  int n_tests = 0, n_fail = 0;
  int hs = 0, wr_n = 0;
  logic [15:0] wa[64], wd[64];

  boot_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16'd4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hs <= hs + int'(rx_valid && rx_ready);
    if (mem_we) begin
      wa[wr_n[5:0]] <= mem_addr;
      wd[wr_n[5:0]] <= mem_wdata;
      wr_n <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      rx_valid = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 32'(n), 0);
    else @(negedge clk);
  endtask

  task automatic send_frame(input bq_t f, input bit gap);
    foreach (f[i]) send(f[i], gap);
    rx_valid = 0;
  endtask

  task automatic do_reset();
    rx_valid = 0;
    reset = 1;
    @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1);
    reset = 0;
  endtask

  initial begin
    bq_t nom = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    bq_t bad = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    bq_t zero = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    bq_t four = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h01, 8'hA5, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'hA5};
    bq_t over = '{8'hA5, 8'h00, 8'h05};
    int base, h0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 0;

    // nominal frame, rx_valid held high across the WRITE cycles
    base = wr_n;
    h0 = hs;
    foreach (nom[i]) begin
      send(nom[i], 0);
      if (i == 4) begin
        check("w1_mem_we", mem_we, 1);
        check("w1_rx_ready", rx_ready, 0);
        check("w1_addr", mem_addr, 16'h0000);
        check("w1_data", mem_wdata, 16'h1234);
      end
      if (i == 6) check("w2_mem_we", mem_we, 1);
    end
    rx_valid = 0;
    check("nom_done", done, 1);
    check("nom_cpu_hold", cpu_hold, 0);
    check("nom_err", err, 0);
    check("nom_rx_ready", rx_ready, 0);
    check("nom_handshakes", 32'(hs - h0), 8);
    check("nom_writes", 32'(wr_n - base), 2);
    check("nom_wa0", wa[base], 16'h0000);
    check("nom_wd0", wd[base], 16'h1234);
    check("nom_wa1", wa[base + 1], 16'h0001);
    check("nom_wd1", wd[base + 1], 16'hABCD);
    @(negedge clk);
    check("nom_addr_hold", mem_addr, 16'h0001);
    check("nom_data_hold", mem_wdata, 16'hABCD);
    do_reset();
    check("rst_done_clr", done, 0);

    // bad checksum
    base = wr_n;
    send_frame(bad, 0);
    check("bad_err", err, 1);
    check("bad_done", done, 0);
    check("bad_cpu_hold", cpu_hold, 1);
    check("bad_writes", 32'(wr_n - base), 2);
    h0 = hs;
    rx_valid = 1;
    rx_data = 8'hA5;
    repeat (4) @(negedge clk);
    rx_valid = 0;
    check("bad_no_accept", 32'(hs - h0), 0);
    check("bad_err_sticky", err, 1);
    check("bad_mem_we", mem_we, 0);
    do_reset();
    check("rst_err_clr", err, 0);

    // leading junk discarded, zero-length image
    base = wr_n;
    send_frame(zero, 0);
    check("zero_done", done, 1);
    check("zero_writes", 32'(wr_n - base), 0);
    do_reset();
    base = wr_n;
    send_frame(zero, 1);
    check("zgap_done", done, 1);
    check("zgap_cpu_hold", cpu_hold, 0);
    check("zgap_writes", 32'(wr_n - base), 0);
    do_reset();

    // count == MAX_WORDS accepted, sync byte value treated as data
    base = wr_n;
    send_frame(four, 1);
    check("four_done", done, 1);
    check("four_writes", 32'(wr_n - base), 4);
    check("four_wa3", wa[base + 3], 16'h0003);
    check("four_wd1", wd[base + 1], 16'hA502);
    check("four_wd3", wd[base + 3], 16'h0004);
    do_reset();

    // oversize count
    base = wr_n;
    send_frame(over, 0);
    check("over_err", err, 1);
    check("over_rx_ready", rx_ready, 0);
    repeat (3) @(negedge clk);
    check("over_writes", 32'(wr_n - base), 0);
    do_reset();

    // reset after the first write, then a full frame
    base = wr_n;
    for (int i = 0; i < 5; i++) send(nom[i], 0);
    rx_valid = 0;
    @(negedge clk);
    check("mid_writes", 32'(wr_n - base), 1);
    do_reset();
    check("mid_addr_rst", mem_addr, 16'h0000);
    check("mid_rx_ready", rx_ready, 1);
    base = wr_n;
    send_frame(nom, 0);
    check("mid_done", done, 1);
    check("mid_writes2", 32'(wr_n - base), 2);
    check("mid_wa0", wa[base], 16'h0000);
    check("mid_wd1", wd[base + 1], 16'hABCD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
